// File: rtl/qq_pkg.sv
// qq_pkg: types and helpers shared by the QuickQ v2 address and read-data stages.
package qq_pkg;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_t;

    localparam int QQ_MAX_W = 64;

    function automatic int unsigned idx_bits(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Callers zero-extend their word; extra zeros leave the parity unchanged.
    function automatic logic parity(input logic [QQ_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/qq_out_buf.sv
// qq_out_buf: 2-entry FIFO-ordered output buffer; dout is always the oldest word,
// rd_stall is registered so consumer ready never reaches it combinationally.
module qq_out_buf
    import qq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         push_par,
    input  logic         dout_ready,
    output logic         rd_stall,
    output logic [W-1:0] dout,
    output logic         dout_valid,
    output logic         par_err
);

    buf_state_t   state;
    logic [W-1:0] tail;
    logic         tail_par;
    logic         head_par;
    logic         pop;

    assign pop     = dout_valid && dout_ready;
    assign par_err = dout_valid && head_par;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= EMPTY;
            dout       <= '0;
            dout_valid <= 1'b0;
            rd_stall   <= 1'b0;
            head_par   <= 1'b0;
            tail       <= '0;
            tail_par   <= 1'b0;
        end else begin
            case (state)
                EMPTY: if (push) begin
                    state      <= ONE;
                    dout       <= push_data;
                    head_par   <= push_par;
                    dout_valid <= 1'b1;
                end
                ONE: if (push && pop) begin
                    dout     <= push_data;
                    head_par <= push_par;
                end else if (push) begin
                    state    <= TWO;
                    tail     <= push_data;
                    tail_par <= push_par;
                    rd_stall <= 1'b1;
                end else if (pop) begin
                    state      <= EMPTY;
                    dout_valid <= 1'b0;
                end
                TWO: if (pop) begin
                    state    <= ONE;
                    dout     <= tail;
                    head_par <= tail_par;
                    rd_stall <= 1'b0;
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/qq_rd_port.sv
// qq_rd_port: QuickQ v2 read-data stage -- storage array, write-first fetch, output buffer.
// Define QQ_PARITY_EN to store an even-parity bit per entry and flag bad words on par_err.
module qq_rd_port
    import qq_pkg::*;
#(
    parameter int D = 4,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [$clog2(D)-1:0] wr_addr,
    input  logic [W-1:0]         wr_data,
    input  logic                 rd_en,
    input  logic [$clog2(D)-1:0] rd_addr,
    output logic                 rd_stall,
    output logic [W-1:0]         dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 ovf_err,
    output logic                 par_err
);

    localparam int DW = $clog2(D);
`ifdef QQ_PARITY_EN
    localparam int MW = W + 1;
`else
    localparam int MW = W;
`endif

    logic [MW-1:0] mem [D];
    logic [MW-1:0] wr_word;
    logic [MW-1:0] fetched;
    logic [DW-1:0] rd_idx;
    logic          push;
    logic          push_par;

`ifdef QQ_PARITY_EN
    assign wr_word  = {parity(QQ_MAX_W'(wr_data)), wr_data};
    assign push_par = parity(QQ_MAX_W'(fetched[W-1:0])) ^ fetched[W];
`else
    assign wr_word  = wr_data;
    assign push_par = 1'b0;
`endif

    assign rd_idx  = rd_addr;
    assign fetched = (wr_en && wr_addr == rd_idx) ? wr_word : mem[rd_idx];
    assign push    = rd_en && !rd_stall;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ovf_err <= 1'b0;
        else if (rd_en && rd_stall) ovf_err <= 1'b1;
    end

    qq_out_buf #(.W(W)) u_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (fetched[W-1:0]),
        .push_par   (push_par),
        .dout_ready (dout_ready),
        .rd_stall   (rd_stall),
        .dout       (dout),
        .dout_valid (dout_valid),
        .par_err    (par_err)
    );

endmodule
